// File: rtl/multicycle_controller_if.sv
// Memory-port handshake between the multicycle controller (master) and the unified memory (slave).
interface multicycle_controller_if;
  logic mem_req;
  logic mem_write;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_write,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_write,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multicycle RV32I datapath with a bounded memory wait and sticky trap.
// Define MC_JAL_EN to add the JAL state; without it opcode 1101111 traps.
module multicycle_controller #(
  parameter int WAIT_LIMIT = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  multicycle_controller_if.master         mem_bus,
  input  logic [6:0]                      op,
  input  logic [2:0]                      funct3,
  input  logic                            funct7b5,
  input  logic                            zero,
  output logic                            adr_src,
  output logic                            ir_write,
  output logic                            pc_write,
  output logic                            reg_write,
  output logic [1:0]                      imm_src,
  output logic [1:0]                      alu_src_a,
  output logic [1:0]                      alu_src_b,
  output logic [1:0]                      result_src,
  output logic [2:0]                      alu_control,
  output logic                            trap,
  output logic [3:0]                      state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
`ifdef MC_JAL_EN
    S_JAL      = 4'd10,
`endif
    S_TRAP     = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MC_JAL_EN
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`endif

  localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam int LIMIT_M1 = (WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0;
  localparam logic [CNT_W-1:0] LIMIT_LAST = LIMIT_M1[CNT_W-1:0];

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             trap_q, trap_d;
  logic             timeout;
  logic [CNT_W-1:0] count_inc;

  // funct7b5 only selects subtract for register-register ops; addi ignores it.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
    logic [2:0] ctl;
    ctl = 3'b000;
    case (f3)
      3'b000:  ctl = sub_ok ? 3'b001 : 3'b000;
      3'b010:  ctl = 3'b101;
      3'b110:  ctl = 3'b011;
      3'b111:  ctl = 3'b010;
      default: ctl = 3'b000;
    endcase
    return ctl;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      count_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      trap_q  <= trap_d;
    end
  end

  // The counter only grows while a memory state stalls, so any transition clears it.
  always_comb begin
    timeout   = (WAIT_LIMIT != 0) && (count_q == LIMIT_LAST);
    count_inc = (WAIT_LIMIT == 0) ? count_q : count_q + 1'b1;
    state_d   = state_q;
    count_d   = '0;

    case (state_q)
      S_FETCH: begin
        if (mem_bus.mem_ready)  state_d = S_DECODE;
        else if (timeout)       state_d = S_TRAP;
        else                    count_d = count_inc;
      end
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BEQ;
`ifdef MC_JAL_EN
          OP_JAL:            state_d = S_JAL;
`endif
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: begin
        if (mem_bus.mem_ready)  state_d = S_MEMWB;
        else if (timeout)       state_d = S_TRAP;
        else                    count_d = count_inc;
      end
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWRITE: begin
        if (mem_bus.mem_ready)  state_d = S_FETCH;
        else if (timeout)       state_d = S_TRAP;
        else                    count_d = count_inc;
      end
      S_EXECR:   state_d = S_ALUWB;
      S_EXECI:   state_d = S_ALUWB;
      S_ALUWB:   state_d = S_FETCH;
      S_BEQ:     state_d = S_FETCH;
`ifdef MC_JAL_EN
      S_JAL:     state_d = S_ALUWB;
`endif
      S_TRAP:    state_d = S_TRAP;
      default:   state_d = S_TRAP;
    endcase

    trap_d = trap_q | (state_d == S_TRAP);
  end

  // Moore decode; write strobes are forced low while reset is held.
  always_comb begin
    mem_bus.mem_req   = 1'b0;
    mem_bus.mem_write = 1'b0;
    adr_src           = 1'b0;
    ir_write          = 1'b0;
    pc_write          = 1'b0;
    reg_write         = 1'b0;
    imm_src           = 2'b00;
    alu_src_a         = 2'b00;
    alu_src_b         = 2'b00;
    result_src        = 2'b00;
    alu_control       = 3'b000;

    case (state_q)
      S_FETCH: begin
        mem_bus.mem_req = 1'b1;
        alu_src_b       = 2'b10;
        result_src      = 2'b10;
        ir_write        = mem_bus.mem_ready;
        pc_write        = mem_bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
`ifdef MC_JAL_EN
        imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
`else
        imm_src   = 2'b10;
`endif
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_STORE) ? 2'b01 : 2'b00;
      end
      S_MEMREAD: begin
        mem_bus.mem_req = 1'b1;
        adr_src         = 1'b1;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_bus.mem_req   = 1'b1;
        mem_bus.mem_write = 1'b1;
        adr_src           = 1'b1;
      end
      S_EXECR: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = alu_decode(funct3, funct7b5);
      end
      S_EXECI: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b01;
        imm_src     = 2'b00;
        alu_control = alu_decode(funct3, 1'b0);
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
      end
      S_BEQ: begin
        alu_src_a   = 2'b10;
        alu_src_b   = 2'b00;
        alu_control = 3'b001;
        result_src  = 2'b00;
        pc_write    = zero;
      end
`ifdef MC_JAL_EN
      S_JAL: begin
        alu_src_a   = 2'b01;
        alu_src_b   = 2'b10;
        alu_control = 3'b000;
        result_src  = 2'b00;
        pc_write    = 1'b1;
      end
`endif
      default: ;
    endcase

    if (!rst_n) begin
      ir_write          = 1'b0;
      pc_write          = 1'b0;
      reg_write         = 1'b0;
      mem_bus.mem_write = 1'b0;
    end
  end

  assign trap  = trap_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: table-driven instruction traces plus trap/reset sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       adr_src, ir_write, pc_write, reg_write, trap;
  logic [1:0] imm_src, alu_src_a, alu_src_b, result_src;
  logic [2:0] alu_control;
  logic [3:0] state;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  multicycle_controller_if mem_bus ();

  multicycle_controller #(.WAIT_LIMIT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_bus     (mem_bus.master),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .imm_src     (imm_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .alu_control (alu_control),
    .trap        (trap),
    .state       (state)
  );

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic        zero;
    logic [3:0]  stall_state;
    int          stalls;
    logic [31:0] trace;
    int          len;
    logic [2:0]  alu;
    logic [1:0]  wb_src;
    int          n_reg;
    int          n_pc;
    int          n_mem;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] exp_q[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input string name, input logic [6:0] opc, input logic [2:0] f3,
                              input logic f7b5, input logic z, input logic [3:0] st_state,
                              input int stalls, input logic [31:0] trace, input int len,
                              input logic [2:0] alu, input logic [1:0] wb_src,
                              input int n_reg, input int n_pc, input int n_mem);
    vec_t v;
    v.name = name; v.op = opc; v.f3 = f3; v.f7b5 = f7b5; v.zero = z;
    v.stall_state = st_state; v.stalls = stalls; v.trace = trace; v.len = len;
    v.alu = alu; v.wb_src = wb_src; v.n_reg = n_reg; v.n_pc = n_pc; v.n_mem = n_mem;
    return v;
  endfunction

  // Expected states are queued when the instruction is launched and popped one per cycle.
  task automatic apply_stimulus(input vec_t v);
    int         stalls_left;
    int         n_reg, n_pc, n_mem, n_ir;
    logic [3:0] exp_state;
    logic [3:0] exp_pop;
    stalls_left = v.stalls;
    n_reg = 0; n_pc = 0; n_mem = 0; n_ir = 0;
    for (int k = 0; k < v.len; k++) exp_q.push_back(v.trace[4*(v.len-1-k) +: 4]);
    for (int k = 0; k < v.len; k++) begin
      exp_state = v.trace[4*(v.len-1-k) +: 4];
      op = v.op; funct3 = v.f3; funct7b5 = v.f7b5; zero = v.zero;
      if (exp_state == 4'd0 || exp_state == 4'd3 || exp_state == 4'd5) begin
        if (exp_state == v.stall_state && stalls_left > 0) begin
          mem_bus.mem_ready = 1'b0;
          stalls_left--;
        end else begin
          mem_bus.mem_ready = 1'b1;
        end
      end else begin
        mem_bus.mem_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      if (exp_q.size() == 0) begin
        check_output({v.name, "_queue"}, 32'd0, 32'd1);
      end else begin
        exp_pop = exp_q.pop_front();
        check_output({v.name, "_state"}, {28'd0, state}, {28'd0, exp_pop});
      end
      if (exp_state == 4'd6 || exp_state == 4'd7 || exp_state == 4'd9)
        check_output({v.name, "_alu"}, {29'd0, alu_control}, {29'd0, v.alu});
      if (reg_write) begin
        n_reg++;
        check_output({v.name, "_wbsrc"}, {30'd0, result_src}, {30'd0, v.wb_src});
      end
      if (pc_write) n_pc++;
      if (mem_bus.mem_write) n_mem++;
      if (ir_write) n_ir++;
      next_cycle();
    end
    check_output({v.name, "_nreg"}, n_reg, v.n_reg);
    check_output({v.name, "_npc"},  n_pc,  v.n_pc);
    check_output({v.name, "_nmem"}, n_mem, v.n_mem);
    check_output({v.name, "_nir"},  n_ir,  1);
  endtask

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    #1;
    check_output({name, "_rst_state"}, {28'd0, state}, 32'd0);
    check_output({name, "_rst_trap"},  {31'd0, trap},  32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_to_trap(input string name, input logic [6:0] opc);
    op = opc; funct3 = 3'b000; funct7b5 = 1'b0; mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    check_output({name, "_fetch"}, {28'd0, state}, 32'd0);
    next_cycle();
    @(negedge clk);
    check_output({name, "_decode"}, {28'd0, state}, 32'd1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      mem_bus.mem_ready = 1'(i & 1);
      @(negedge clk);
      check_output({name, "_state"}, {28'd0, state}, 32'd15);
      check_output({name, "_trap"},  {31'd0, trap},  32'd1);
      check_output({name, "_strobes"}, {28'd0, mem_bus.mem_req, pc_write, ir_write, reg_write}, 32'd0);
      next_cycle();
    end
    do_reset(name);
  endtask

  // Drives a store up to its MEMWRITE state; returns at posedge+1 with MEMWRITE current.
  task automatic store_to_memwrite();
    op = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0; mem_bus.mem_ready = 1'b1;
    next_cycle();
    next_cycle();
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0; op = 7'd0; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    mem_bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_state",    {28'd0, state},       32'd0);
    check_output("rst_mem_req",  {31'd0, mem_bus.mem_req}, 32'd1);
    check_output("rst_alu_b",    {30'd0, alu_src_b},   32'd2);
    check_output("rst_res_src",  {30'd0, result_src},  32'd2);
    check_output("rst_strobes",  {27'd0, ir_write, pc_write, reg_write, mem_bus.mem_write, trap}, 32'd0);
    check_output("rst_misc",     {22'd0, adr_src, imm_src, alu_src_a, alu_control}, 32'd0);
    rst_n = 1'b1;

    //                name        op          f3      f7 z  stall  n  trace          len alu     wb     reg pc mem
    vecs.push_back(mk("add",     7'b0110011, 3'b000, 0, 0, 4'd0, 0, 32'h0168,     4, 3'b000, 2'b00, 1, 1, 0));
    vecs.push_back(mk("sub",     7'b0110011, 3'b000, 1, 0, 4'd0, 0, 32'h0168,     4, 3'b001, 2'b00, 1, 1, 0));
    vecs.push_back(mk("addi_f7", 7'b0010011, 3'b000, 1, 0, 4'd0, 0, 32'h0178,     4, 3'b000, 2'b00, 1, 1, 0));
    vecs.push_back(mk("slt",     7'b0110011, 3'b010, 0, 0, 4'd0, 0, 32'h0168,     4, 3'b101, 2'b00, 1, 1, 0));
    vecs.push_back(mk("ori",     7'b0010011, 3'b110, 0, 0, 4'd0, 0, 32'h0178,     4, 3'b011, 2'b00, 1, 1, 0));
    vecs.push_back(mk("and",     7'b0110011, 3'b111, 1, 0, 4'd0, 0, 32'h0168,     4, 3'b010, 2'b00, 1, 1, 0));
    vecs.push_back(mk("xori",    7'b0010011, 3'b100, 0, 0, 4'd0, 0, 32'h0178,     4, 3'b000, 2'b00, 1, 1, 0));
    vecs.push_back(mk("lw",      7'b0000011, 3'b010, 0, 0, 4'd0, 0, 32'h01234,    5, 3'b000, 2'b01, 1, 1, 0));
    vecs.push_back(mk("lw_wait3",7'b0000011, 3'b010, 0, 0, 4'd3, 3, 32'h01233334, 8, 3'b000, 2'b01, 1, 1, 0));
    vecs.push_back(mk("sw",      7'b0100011, 3'b010, 0, 0, 4'd0, 0, 32'h0125,     4, 3'b000, 2'b00, 0, 1, 1));
    vecs.push_back(mk("sw_wait2",7'b0100011, 3'b010, 0, 0, 4'd5, 2, 32'h012555,   6, 3'b000, 2'b00, 0, 1, 3));
    vecs.push_back(mk("beq_z1",  7'b1100011, 3'b000, 0, 1, 4'd0, 0, 32'h019,      3, 3'b001, 2'b00, 0, 2, 0));
    vecs.push_back(mk("beq_z0",  7'b1100011, 3'b000, 0, 0, 4'd0, 0, 32'h019,      3, 3'b001, 2'b00, 0, 1, 0));
    vecs.push_back(mk("add_fw2", 7'b0110011, 3'b000, 0, 0, 4'd0, 2, 32'h000168,   6, 3'b000, 2'b00, 1, 1, 0));
`ifdef MC_JAL_EN
    vecs.push_back(mk("jal",     7'b1101111, 3'b000, 0, 0, 4'd0, 0, 32'h01A8,     4, 3'b000, 2'b00, 1, 2, 0));
`endif

    foreach (vecs[i]) apply_stimulus(vecs[i]);

    // Illegal opcode parks the core until reset.
    run_to_trap("illegal", 7'b0000000);
`ifndef MC_JAL_EN
    run_to_trap("jal_off", 7'b1101111);
`endif

    // Fetch timeout: four stalled cycles at WAIT_LIMIT=4, then TRAP.
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("to_fetch_wait", {28'd0, state}, 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check_output("to_fetch_state", {28'd0, state}, 32'd15);
    check_output("to_fetch_trap",  {31'd0, trap},  32'd1);
    next_cycle();
    do_reset("to_fetch");

    // Store timeout in MEMWRITE.
    store_to_memwrite();
    mem_bus.mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_output("to_sw_wait", {27'd0, state, mem_bus.mem_write}, {27'd0, 4'd5, 1'b1});
      next_cycle();
    end
    @(negedge clk);
    check_output("to_sw_state", {28'd0, state}, 32'd15);
    check_output("to_sw_wr",    {31'd0, mem_bus.mem_write}, 32'd0);
    next_cycle();
    do_reset("to_sw");

    // Reset arriving mid-store drops the write strobe immediately.
    store_to_memwrite();
    mem_bus.mem_ready = 1'b0;
    @(negedge clk);
    check_output("mid_wr_before", {31'd0, mem_bus.mem_write}, 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check_output("mid_wr_after", {31'd0, mem_bus.mem_write}, 32'd0);
    check_output("mid_state",    {28'd0, state}, 32'd0);
    check_output("mid_req",      {31'd0, mem_bus.mem_req}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mem_bus.mem_ready = 1'b1;
    @(negedge clk);
    check_output("post_rst_fetch", {29'd0, state, ir_write}, {29'd0, 4'd0, 1'b1});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Sequencing controller for the multicycle RV32I core: a Moore FSM that drives one shared ALU, one unified instruction/data memory port, the instruction register and the register file across several cycles per instruction. It replaces the single-cycle decoder in the multicycle datapath. Memory accesses use a req/ready handshake with a bounded wait. Unsupported opcodes and bus timeouts park the core in a sticky trap state.

## Interface
- WAIT_LIMIT, 255: max cycles a memory state waits for mem_ready before trapping; 0 = wait forever
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instr[6:0] from instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the access this cycle
- mem_req  out  1  memory access request
- mem_write  out  1  store strobe, only with mem_req
- adr_src  out  1  0 = PC, 1 = ALUOut
- ir_write  out  1  latch instruction and OldPC
- pc_write  out  1  PC load enable
- reg_write  out  1  register file write
- imm_src  out  2  00 I, 01 S, 10 B, 11 J
- alu_src_a  out  2  00 PC, 01 OldPC, 10 rs1
- alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
- result_src  out  2  00 ALUOut, 01 read data, 10 ALU result
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- trap  out  1  sticky illegal-opcode/timeout flag
- state  out  4  current state, debug

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BEQ 9, JAL 10, TRAP 15.
- Outputs are decoded from state only, plus pc_write/ir_write gating; unlisted outputs are 0 in every state.
- FETCH: mem_req=1, adr_src=0, a=00, b=10, alu add, result_src=10; on mem_ready: ir_write=1, pc_write=1, go DECODE; else stay.
- DECODE: a=01, b=01, imm_src=10, alu add (branch target into ALUOut). Next by op: 0000011/0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL; other → TRAP.
- MEMADR: a=10, b=01, add, imm_src=00 for loads, 01 for stores; → MEMREAD (load) or MEMWRITE (store).
- MEMREAD: mem_req=1, adr_src=1; on mem_ready → MEMWB. MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; on mem_ready → FETCH.
- EXECR: a=10, b=00, ALU decode → ALUWB. EXECI: a=10, b=01, imm_src=00, ALU decode → ALUWB.
- ALU decode: funct3 000 → sub if EXECR and funct7b5, else add; 010 slt; 110 or; 111 and; other → add.
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BEQ: a=10, b=00, sub, result_src=00, pc_write=zero → FETCH.
- JAL: a=01, b=10, add, result_src=00, pc_write=1 (PC ← ALUOut target) → ALUWB (rd ← OldPC+4).
- Timeout: wait counter clears on entry to FETCH/MEMREAD/MEMWRITE; increments per cycle without mem_ready; reaching WAIT_LIMIT with mem_ready low → TRAP. mem_ready on the limit cycle wins.
- TRAP: trap=1, all strobes 0; held until rst_n low.

## Timing
- Reset (async assert, sync release): state=FETCH, counter=0, trap=0; outputs equal FETCH decode: mem_req=1, alu_src_b=10, result_src=10, rest 0.
- Zero-wait-state cycle counts: R/I 4, lw 5, sw 4, beq 3, jal 4.
- Each mem_ready low cycle adds one cycle; mem_ready ignored outside memory states.
- Reset mid-instruction aborts it; no write strobe asserted in the reset cycle.

## Configuration
- MC_JAL_EN defined: JAL state present, op 1101111 decoded as above.
- Undefined: JAL state absent; op 1101111 → TRAP; imm_src 11 never driven.

## Test plan
- add x3,x1,x2 (op 0110011, f3 000, f7b5 0), mem_ready=1 → states 0,1,6,8,0; alu_control 000 in EXECR, reg_write only in ALUWB.
- sub (f7b5=1) and addi with f7b5=1 → alu_control 001 for sub, 000 for addi.
- lw with mem_ready low 3 cycles in MEMREAD → 8 total cycles, one reg_write with result_src=01.
- beq, zero=1 then zero=0 → pc_write high one cycle in BEQ only when zero=1.
- WAIT_LIMIT=4, mem_ready held 0 in FETCH → TRAP after 4 cycles, trap=1 until rst_n low, then state=0.
- op 1101111 → JAL then ALUWB with MC_JAL_EN; TRAP without it.
